// File: rtl/attack_hit_detect.sv
// attack_hit_detect: runs one attack's startup/active/recovery frame timeline
// and, on frame ticks during the active window, tests the attacker hitbox
// against the defender hurtbox. A landed hit yields a one-cycle got_hit pulse
// plus the damage for the attack type; at most one hit lands per attack.
//
// Output contract: got_hit is a single-cycle strobe with no back-pressure;
// hit_damage is valid in the cycle got_hit=1 and holds its value otherwise.
// attack_phase exposes the FSM state directly for observation.
module attack_hit_detect #(
  parameter int BODY_W   = 32,
  parameter int HIT_W    = 24,
  parameter int HIT_H    = 16,
  parameter int HIT_YOFF = 8,
  parameter int HURT_W   = 32,
  parameter int HURT_H   = 48
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       attack_start,
  input  logic [1:0] attack_type,
  input  logic       facing_right,
  input  logic [9:0] atk_x,
  input  logic [9:0] atk_y,
  input  logic [9:0] def_x,
  input  logic [9:0] def_y,
  input  logic       def_hitstun,
  output logic       got_hit,
  output logic [5:0] hit_damage,
  output logic       attack_busy,
  output logic [1:0] attack_phase,
  output logic       hit_landed
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_STARTUP  = 2'd1,
    S_ACTIVE   = 2'd2,
    S_RECOVERY = 2'd3
  } phase_t;

  localparam logic signed [10:0] C_BODY_W   = 11'(BODY_W);
  localparam logic signed [10:0] C_HIT_W    = 11'(HIT_W);
  localparam logic signed [10:0] C_HIT_H    = 11'(HIT_H);
  localparam logic signed [10:0] C_HIT_YOFF = 11'(HIT_YOFF);
  localparam logic signed [10:0] C_HURT_W   = 11'(HURT_W);
  localparam logic signed [10:0] C_HURT_H   = 11'(HURT_H);

  // Frame table lookups; the reserved type 3 behaves as a jab.
  function automatic logic [4:0] f_startup(input logic [1:0] t);
    case (t)
      2'd1:    f_startup = 5'd5;
      2'd2:    f_startup = 5'd12;
      default: f_startup = 5'd3;
    endcase
  endfunction

  function automatic logic [4:0] f_active(input logic [1:0] t);
    case (t)
      2'd1:    f_active = 5'd3;
      2'd2:    f_active = 5'd4;
      default: f_active = 5'd2;
    endcase
  endfunction

  function automatic logic [4:0] f_recovery(input logic [1:0] t);
    case (t)
      2'd1:    f_recovery = 5'd10;
      2'd2:    f_recovery = 5'd20;
      default: f_recovery = 5'd6;
    endcase
  endfunction

  function automatic logic [5:0] f_damage(input logic [1:0] t);
    case (t)
      2'd1:    f_damage = 6'd6;
      2'd2:    f_damage = 6'd12;
      default: f_damage = 6'd3;
    endcase
  endfunction

  phase_t      r_state;
  phase_t      w_state_nxt;
  logic [4:0]  r_cnt;
  logic [4:0]  w_cnt_nxt;
  logic [1:0]  r_type;
  logic        r_facing;
  logic        r_hit;
  logic [5:0]  r_dmg;
  logic        r_landed;
  logic        w_start;
  logic        w_fire;

  // Geometry in 11-bit signed so the left-facing subtraction can go negative
  // before clamping.
  logic signed [10:0] w_ax;
  logic signed [10:0] w_ay;
  logic signed [10:0] w_dx;
  logic signed [10:0] w_dy;
  logic signed [10:0] w_left;
  logic signed [10:0] w_hx0;
  logic signed [10:0] w_hx1;
  logic signed [10:0] w_hy0;
  logic signed [10:0] w_hy1;
  logic signed [10:0] w_dx1;
  logic signed [10:0] w_dy1;
  logic               w_overlap;

  assign w_ax   = signed'({1'b0, atk_x});
  assign w_ay   = signed'({1'b0, atk_y});
  assign w_dx   = signed'({1'b0, def_x});
  assign w_dy   = signed'({1'b0, def_y});
  assign w_left = w_ax - C_HIT_W;
  assign w_hx0  = r_facing ? (w_ax + C_BODY_W) : (w_left[10] ? 11'sd0 : w_left);
  assign w_hx1  = w_hx0 + C_HIT_W;
  assign w_hy0  = w_ay + C_HIT_YOFF;
  assign w_hy1  = w_hy0 + C_HIT_H;
  assign w_dx1  = w_dx + C_HURT_W;
  assign w_dy1  = w_dy + C_HURT_H;

  // Strict inequalities: boxes that only share an edge do not overlap.
  assign w_overlap = (w_hx0 < w_dx1) && (w_dx < w_hx1) &&
                     (w_hy0 < w_dy1) && (w_dy < w_hy1);

  // Next-state, counter reload and hit decision for the attack timeline.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_start     = 1'b0;
    w_fire      = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A coincident frame_tick is swallowed here: the load wins.
        if (attack_start) begin
          w_start     = 1'b1;
          w_state_nxt = S_STARTUP;
          w_cnt_nxt   = f_startup(attack_type);
        end
      end
      default: begin
        if (frame_tick) begin
          if ((r_state == S_ACTIVE) && w_overlap && !r_landed && !def_hitstun) begin
            w_fire = 1'b1;
          end
          if (r_cnt == 5'd1) begin
            case (r_state)
              S_STARTUP: begin
                w_state_nxt = S_ACTIVE;
                w_cnt_nxt   = f_active(r_type);
              end
              S_ACTIVE: begin
                w_state_nxt = S_RECOVERY;
                w_cnt_nxt   = f_recovery(r_type);
              end
              default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 5'd0;
              end
            endcase
          end else begin
            w_cnt_nxt = r_cnt - 5'd1;
          end
        end
      end
    endcase
  end

  // State, latched attack parameters and registered hit outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 5'd0;
      r_type   <= 2'd0;
      r_facing <= 1'b0;
      r_hit    <= 1'b0;
      r_dmg    <= 6'd0;
      r_landed <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_hit   <= w_fire;
      if (w_start) begin
        r_type   <= attack_type;
        r_facing <= facing_right;
        r_landed <= 1'b0;
      end
      if (w_fire) begin
        r_dmg    <= f_damage(r_type);
        r_landed <= 1'b1;
      end
    end
  end

  assign got_hit      = r_hit;
  assign hit_damage   = r_dmg;
  assign attack_busy  = (r_state != S_IDLE);
  assign attack_phase = r_state;
  assign hit_landed   = r_landed;

endmodule

// File: doc/attack_hit_detect.md
Name: attack_hit_detect

Overview:
- Attacker-side stage that runs one attack's frame timeline: startup, then active, then recovery.
- While the attack is active it tests the hitbox against the defender's hurtbox once per frame.
- It emits a single-cycle hit pulse plus a damage amount. These feed the defender's hit/damage FSM inputs `got_hit` and `hit_damage_in` directly.
- One instance exists per attacker; the defender position and hitstun status come from the opposing player.

Parameters:
- BODY_W, default 32: attacker body width in pixels; the hitbox is anchored at the body edge.
- HIT_W, default 24: hitbox width in pixels.
- HIT_H, default 16: hitbox height in pixels.
- HIT_YOFF, default 8: hitbox top offset below the attacker's top y.
- HURT_W, default 32: defender hurtbox width.
- HURT_H, default 48: defender hurtbox height.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- frame_tick  in  1  one-cycle pulse per video frame
- attack_start  in  1  one-cycle request to begin an attack
- attack_type  in  2  0 jab, 1 kick, 2 smash, 3 reserved (treated as jab)
- facing_right  in  1  attacker facing; sampled at attack_start
- atk_x  in  10  attacker top-left x
- atk_y  in  10  attacker top-left y
- def_x  in  10  defender top-left x
- def_y  in  10  defender top-left y
- def_hitstun  in  1  defender currently in hitstun; blocks hits
- got_hit  out  1  one-cycle hit pulse to the defender
- hit_damage  out  6  damage for this hit; valid when got_hit=1, held otherwise
- attack_busy  out  1  high in any state other than IDLE
- attack_phase  out  2  0 IDLE, 1 STARTUP, 2 ACTIVE, 3 RECOVERY
- hit_landed  out  1  sticky: this attack has already connected

Behaviour:
- Interface: one clock domain `clk`. `reset` is synchronous and active-high.
- Reset state:
  - FSM in IDLE, counter 0.
  - got_hit, hit_damage, hit_landed, attack_busy and attack_phase all 0.
  - A reset mid-attack aborts the attack immediately; no pending pulse survives.
- Frame table (startup / active / recovery frames, damage):
  - jab: 3 / 2 / 6, damage 3
  - kick: 5 / 3 / 10, damage 6
  - smash: 12 / 4 / 20, damage 12
- Attack latch: in IDLE, attack_start=1 does all of the following on that clock:
  - latches type and facing_right;
  - enters STARTUP and loads the counter with the startup count;
  - clears hit_landed.
- attack_start is ignored in every state other than IDLE; there is no buffering.
- Counter and phase advance (5-bit counter), on each frame_tick:
  - counter==1: move to the next phase and load that phase's count (STARTUP→ACTIVE→RECOVERY); RECOVERY moves to IDLE.
  - otherwise: decrement the counter.
  - Each phase therefore lasts exactly N frame_ticks.
- Same-cycle start and tick: attack_start and frame_tick in the same cycle in IDLE loads STARTUP; that tick does not decrement.
- Hitbox geometry, computed in 11-bit signed from latched facing and live atk_x/atk_y:
  - facing right: hx0 = atk_x + BODY_W.
  - facing left: hx0 = atk_x − HIT_W, clamped to 0 if negative.
  - hx1 = hx0 + HIT_W.
  - hy0 = atk_y + HIT_YOFF; hy1 = hy0 + HIT_H.
- Hurtbox: [def_x, def_x+HURT_W) by [def_y, def_y+HURT_H).
- Overlap rule: hx0 < def_x+HURT_W, def_x < hx1, hy0 < def_y+HURT_H and def_y < hy1. Edges that only touch do not count as overlap.
- Hit evaluation happens only on a frame_tick cycle while in ACTIVE, including the final ACTIVE tick before the transition. A hit fires when overlap is true, hit_landed=0 and def_hitstun=0. On that cycle:
  - register got_hit=1, so the pulse is visible the cycle after frame_tick;
  - load hit_damage with the type's damage;
  - set hit_landed.
- got_hit drops after exactly one cycle.
- At most one hit per attack.
- A def_hitstun-blocked frame does not set hit_landed, so a later active frame may still connect.
- hit_landed stays high through RECOVERY and IDLE until the next attack_start.
- hit_damage holds its last value; it is 0 only after reset.

Test Plan:
- Jab, facing right, atk=(100,200), def=(140,200), hitstun 0 → STARTUP for 3 ticks, ACTIVE for 2 ticks; exactly one got_hit, 1 cycle after the first ACTIVE frame_tick, hit_damage=3; RECOVERY 6 ticks, then IDLE, with attack_busy=0.
- Smash, facing left, atk=(10,200), def=(0,200) → hx0 clamps to 0; hit with damage 12; only one pulse across all 4 active frames.
- Kick with def_hitstun=1 on active frames 1–2 and 0 on frame 3 → single hit on the 3rd active tick, damage 6; no hit if def_hitstun stays 1 throughout, and hit_landed=0.
- Edge-touch: facing right, atk_x=100, def_x=156 (hx1=156) → no hit; def_x=155 → hit.
- attack_start repeated during ACTIVE/RECOVERY → ignored, timeline unchanged; attack_start coincident with frame_tick in IDLE → full 3 startup ticks still counted.
- Reset asserted during ACTIVE on the cycle a hit would register → next cycle got_hit=0, phase 0, hit_landed=0, hit_damage=0.
